// File: rtl/disp_pkg.sv
// disp_pkg: shared widths, types and the leading-zero blank rule for the digit scanner
package disp_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int NIBBLE_W   = 4;
  localparam int DIG_W      = 2;
  localparam int VALUE_W    = 16;
  typedef logic [DIG_W-1:0] dig_sel_t;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;
  function automatic logic lz_blank(input dig_sel_t k, input logic [VALUE_W-1:0] v);
    return (k != '0) && ((v >> (NIBBLE_W * int'(k))) == '0);
  endfunction
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: divides clk down to a one-cycle tick every CLK_DIV enabled cycles
module scan_prescaler #(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  logic [CW-1:0] count_q, count_d;
  // tick on the last count; count freezes while disabled
  always_comb begin
    tick = enable && (count_q == CW'(CLK_DIV - 1));
    count_d = tick ? '0 : count_q + CW'(enable);
  end
  // count register
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end
endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: 4-digit scan controller with frame-aligned value commit; LEADING_ZERO_BLANK_EN blanks leading zero digits
module digit_scan_ctrl
  import disp_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [VALUE_W-1:0] value_in,
  input  logic               load,
  output logic [VALUE_W-1:0] value,
  output logic [DIG_W-1:0]   dig_sel,
  output logic [NUM_DIGITS-1:0] anode_n,
  output logic               load_pending
);
  logic tick, frame, commit, blank;
  dig_sel_t dig_sel_q, dig_sel_d;
  logic [VALUE_W-1:0] value_q, value_d, pending_q, pending_d;
  logic [NUM_DIGITS-1:0] anode_n_q, anode_n_d;
  logic load_pending_q, load_pending_d;

  scan_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick)
  );

  // slot advance, commit at frame boundary or while dark, anode decode for the slot being entered
  always_comb begin
    frame = tick && (dig_sel_q == dig_sel_t'(NUM_DIGITS - 1));
    commit = load_pending_q && (frame || !enable);
    dig_sel_d = tick ? dig_sel_q + 1'b1 : dig_sel_q;
    value_d = commit ? pending_q : value_q;
    pending_d = load ? value_in : pending_q;
    load_pending_d = load || (load_pending_q && !commit);
`ifdef LEADING_ZERO_BLANK_EN
    blank = lz_blank(dig_sel_d, value_d);
`else
    blank = 1'b0;
`endif
    anode_n_d = (enable && !blank) ? ~(NUM_DIGITS'(1) << dig_sel_d) : ANODE_OFF;
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_sel_q      <= '0;
      value_q        <= '0;
      pending_q      <= '0;
      anode_n_q      <= ANODE_OFF;
      load_pending_q <= 1'b0;
    end else begin
      dig_sel_q      <= dig_sel_d;
      value_q        <= value_d;
      pending_q      <= pending_d;
      anode_n_q      <= anode_n_d;
      load_pending_q <= load_pending_d;
    end
  end

  assign value        = value_q;
  assign dig_sel      = dig_sel_q;
  assign anode_n      = anode_n_q;
  assign load_pending = load_pending_q;
endmodule
